fetch_unit: RTL
===============

# fetch_unit

Instruction fetch front end: owns the architectural fetch PC, issues in-order requests to instruction memory under a valid/ready handshake, and buffers returned words with their PCs for decode. It consumes the next-PC/redirect produced by the branch controller in execute, killing wrong-path work in flight. Sits between imem and decode in the shrv32 core.

## Interface
- BUF_DEPTH, 2, instruction buffer entries; also the cap on outstanding + buffered fetches (power of two, ≥2)
- RESET_VECTOR, 32'h0000_0000, fetch PC after reset
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- redirect_valid  in  1  taken-branch/jump redirect this cycle
- redirect_pc  in  32  redirect target (branch controller output)
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  imem accepts request
- imem_req_addr  out  32  fetch address
- imem_resp_valid  in  1  response valid; in order, ≥1 cycle after acceptance, never back-pressured
- imem_resp_data  in  32  instruction word
- inst_valid  out  1  buffer head valid to decode
- inst_ready  in  1  decode accepts head
- inst_data  out  32  instruction word
- inst_pc  out  32  PC of inst_data
- misalign_fault  out  1  misaligned-redirect fault (only with FETCH_MISALIGN_CHECK_EN; else tied 0)

## Operation
- State machine: RUN, FAULT (FAULT exists only with the macro). Reset → RUN.
- Registers: fetch_pc, outstanding count (0..BUF_DEPTH), drop count (0..BUF_DEPTH), FIFO of {pc, data}.
- Credit: credit_ok = outstanding + count − (inst_valid && inst_ready) < BUF_DEPTH.
- imem_req_valid = RUN && credit_ok && !redirect_valid && !rst; imem_req_addr = fetch_pc.
- Request accepted (valid && ready): fetch_pc += 4 (mod 2^32, wraps 32'hFFFF_FFFC → 0), outstanding++; pc of request pushed into a side PC queue (same depth).
- Response: if drop count > 0, discard and decrement drop count; else push {pc, data} into FIFO. Outstanding-- either way.
- Redirect: FIFO and PC queue flushed; fetch_pc ← redirect_pc; drop count ← outstanding after this cycle's response/acceptance accounting (a response arriving in the redirect cycle is discarded; no request is accepted in the redirect cycle).
- Dequeue and enqueue in same cycle allowed, including at full; FIFO never overflows due to credit rule.
- Redirect outranks dequeue: inst_valid still shown in redirect cycle, but the entry is flushed; decode is responsible for ignoring it (execute issued the redirect).

## Timing
- Reset values: imem_req_valid 0, inst_valid 0, misalign_fault 0, fetch_pc RESET_VECTOR, counts 0, state RUN.
- First request: cycle after rst deasserts, addr RESET_VECTOR.
- Response in cycle M → inst_valid in M+1 (registered FIFO, no bypass).
- Redirect in cycle N → request to redirect_pc in N+1 (if credit).
- Sustained 1 instruction/cycle with 1-cycle imem and BUF_DEPTH=2, inst_ready=1.
- rst mid-operation: all state cleared in that cycle; responses to pre-reset requests are not expected (imem reset together).

## Configuration
- FETCH_MISALIGN_CHECK_EN defined: redirect with redirect_pc[1:0] != 0 flushes as normal, enters FAULT, misalign_fault=1 from next cycle, inst_pc holds faulting target while inst_valid=0, no requests issued; in-flight responses still drained/dropped. Next valid redirect leaves FAULT (or re-enters if also misaligned).
- Undefined: redirect_pc[1:0] forced to 2'b00; misalign_fault constant 0; no FAULT state.

## Structure
- shrv32_pkg: RESET_VECTOR default, fetch state enum, fetch entry struct {pc, data}, ILEN=32.
- Sub-module: fetch_fifo (parameterised synchronous FIFO, depth BUF_DEPTH, flush input), instantiated for the instruction buffer; the PC side queue reuses it.

## Test plan
- Reset release, imem ready, 1-cycle latency, data=addr → requests 0x0,0x4,0x8 on consecutive cycles; inst_pc/inst_data 0x0,0x4,0x8 one per cycle from cycle 2.
- inst_ready=0 for 10 cycles → exactly BUF_DEPTH requests issued, then imem_req_valid=0; release → in-order delivery, no loss.
- Redirect to 0x100 with 2 outstanding on 3-cycle imem → both late responses dropped; next inst_pc = 0x100.
- Redirect coincident with a response → response dropped, request to target next cycle.
- fetch_pc 0xFFFF_FFFC accepted → next request 0x0000_0000.
- Macro on: redirect to 0x102 → misalign_fault=1 next cycle, no requests; redirect to 0x200 → fault clears, fetch resumes at 0x200.

Source files
------------

// File: rtl/shrv32_pkg.sv
// Shared fetch-stage types and constants for the shrv32 core.
package shrv32_pkg;

   localparam int unsigned ILEN = 32;
   localparam logic [ILEN-1:0] RESET_VECTOR_DEF = 32'h0000_0000;

   typedef enum logic {
      FETCH_RUN   = 1'b0,
      FETCH_FAULT = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [ILEN-1:0] pc;
      logic [ILEN-1:0] data;
   } fetch_entry_t;

   function automatic logic [ILEN-1:0] align_pc(input logic [ILEN-1:0] pc);
      return pc & ~ILEN'(3);
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// imem request/response and decode-side handshake bundle for the fetch unit.
interface fetch_unit_if;
   import shrv32_pkg::*;

   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [ILEN-1:0] imem_req_addr;
   logic            imem_resp_valid;
   logic [ILEN-1:0] imem_resp_data;
   logic            inst_valid;
   logic            inst_ready;
   logic [ILEN-1:0] inst_data;
   logic [ILEN-1:0] inst_pc;

   modport master (
      output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
      input  imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
      output imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready
   );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; push while full is accepted only alongside a pop.
module fetch_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         push_data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         pop_data_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   always_comb begin
      do_pop   = pop_i && (count_q != '0);
      do_push  = push_i && ((count_q != CW'(DEPTH)) || do_pop);
      rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      count_d  = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + CW'(1);
      end else if (!do_push && do_pop) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush_i) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   assign pop_data_o = mem_q[rd_ptr_q];
   assign count_o    = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: in-order imem requests under a credit limit, buffered {pc, data} for decode.
// Optional FETCH_MISALIGN_CHECK_EN: misaligned redirect targets enter a FAULT state instead of being aligned.
module fetch_unit import shrv32_pkg::*; #(
   parameter int unsigned     BUF_DEPTH    = 2,
   parameter logic [ILEN-1:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             redirect_valid,
   input  logic [ILEN-1:0]  redirect_pc,
   fetch_unit_if.master     bus,
   output logic             misalign_fault
);

   localparam int unsigned CNTW = $clog2(BUF_DEPTH) + 1;

   fetch_state_e    state_q, state_d;
   logic [ILEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [CNTW-1:0] outst_q, outst_d;
   logic [CNTW-1:0] drop_q, drop_d;

   logic            run, ibuf_valid, deq, req_valid, req_fire;
   logic            resp_drop, resp_keep, redirect_fault;
   logic [CNTW:0]   credit_use;
   logic [ILEN-1:0] redirect_tgt;
   fetch_entry_t    ibuf_head;
   logic [CNTW-1:0] ibuf_count, pcq_count;
   logic [ILEN-1:0] pcq_head;

`ifdef FETCH_MISALIGN_CHECK_EN
   assign redirect_tgt   = redirect_pc;
   assign redirect_fault = (redirect_pc[1:0] != 2'b00);
`else
   assign redirect_tgt   = align_pc(redirect_pc);
   assign redirect_fault = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FETCH_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (redirect_valid) begin
         state_d = redirect_fault ? FETCH_FAULT : FETCH_RUN;
      end
   end

   // Credit counts everything in flight or buffered, less the entry leaving this cycle.
   always_comb begin
      run        = (state_q == FETCH_RUN);
      ibuf_valid = run && (ibuf_count != '0);
      deq        = ibuf_valid && bus.inst_ready;
      credit_use = {1'b0, outst_q} + {1'b0, ibuf_count} - (CNTW+1)'(deq);
      req_valid  = run && (credit_use < (CNTW+1)'(BUF_DEPTH)) && !redirect_valid && !rst;

      bus.imem_req_valid = req_valid;
      bus.imem_req_addr  = fetch_pc_q;
      bus.inst_valid     = ibuf_valid;
      bus.inst_data      = ibuf_head.data;
      bus.inst_pc        = ibuf_head.pc;
      misalign_fault     = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      if (!run) begin
         bus.inst_pc = fetch_pc_q;
      end
      misalign_fault = !run;
`endif
   end

   // Drop count after a redirect covers every request still in flight, old drops included.
   always_comb begin
      req_fire   = req_valid && bus.imem_req_ready;
      resp_drop  = bus.imem_resp_valid && ((drop_q != '0) || redirect_valid);
      resp_keep  = bus.imem_resp_valid && !resp_drop && (pcq_count != '0);
      fetch_pc_d = req_fire ? fetch_pc_q + ILEN'(4) : fetch_pc_q;
      outst_d    = outst_q + CNTW'(req_fire) - CNTW'(bus.imem_resp_valid);
      drop_d     = drop_q;
      if (redirect_valid) begin
         fetch_pc_d = redirect_tgt;
         drop_d     = outst_d;
      end else if (resp_drop) begin
         drop_d = drop_q - CNTW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q <= RESET_VECTOR;
         outst_q    <= '0;
         drop_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         outst_q    <= outst_d;
         drop_q     <= drop_d;
      end
   end

   fetch_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (BUF_DEPTH)
   ) u_ibuf (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (redirect_valid),
      .push_i      (resp_keep),
      .push_data_i ({pcq_head, bus.imem_resp_data}),
      .pop_i       (deq),
      .pop_data_o  (ibuf_head),
      .count_o     (ibuf_count)
   );

   fetch_fifo #(
      .WIDTH (ILEN),
      .DEPTH (BUF_DEPTH)
   ) u_pcq (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (redirect_valid),
      .push_i      (req_fire),
      .push_data_i (fetch_pc_q),
      .pop_i       (resp_keep),
      .pop_data_o  (pcq_head),
      .count_o     (pcq_count)
   );

endmodule
